// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision field definitions for the FP ALU datapath.
package fp32_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int          EXP_BIAS = 127;

  localparam logic [EXP_W-1:0] EXP_MAX      = 8'hFF;
  localparam logic [31:0]      FP32_POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp32_adder_if.sv
// Operand/result bundle for fp32_adder; master drives operands, slave returns results.
interface fp32_adder_if;

  logic        in_valid;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        out_valid;
  logic [31:0] result;
  logic        Exception;

  modport master (
    output in_valid, a_operand, b_operand,
    input  out_valid, result, Exception
  );

  modport slave (
    input  in_valid, a_operand, b_operand,
    output out_valid, result, Exception
  );

endinterface

// File: rtl/fp32_lzc.sv
// Leading-zero counter used to renormalize the mantissa after subtraction.
module fp32_lzc #(
  parameter int unsigned WIDTH = 24
) (
  input  logic [WIDTH-1:0] value,
  output logic [4:0]       count
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (value[i]) count = 5'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp32_adder.sv
// Single-precision adder, DAZ/flush-to-zero, truncating; one output register stage.
// Define FP_ADD_RNE_EN for round-to-nearest-even with guard/round/sticky bits.
module fp32_adder
  import fp32_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  fp32_adder_if.slave  bus
);

`ifdef FP_ADD_RNE_EN
  localparam int unsigned G = 3;
`else
  localparam int unsigned G = 0;
`endif
  localparam int unsigned W = 24 + G;

  fp32_t a, b, a_eff, b_eff, lg, sm;
  logic         swap;
  logic [7:0]   diff;
  logic [W-1:0] ext_l, ext_s, shifted;
  logic [W:0]   sum;
  logic [4:0]   lzc;

  assign a = fp32_t'(bus.a_operand);
  assign b = fp32_t'(bus.b_operand);

  always_comb begin
    a_eff = a;
    b_eff = b;
    if (a.exp == '0) begin
      a_eff.exp  = '0;
      a_eff.frac = '0;
    end
    if (b.exp == '0) begin
      b_eff.exp  = '0;
      b_eff.frac = '0;
    end
    swap  = {b_eff.exp, b_eff.frac} > {a_eff.exp, a_eff.frac};
    lg    = swap ? b_eff : a_eff;
    sm    = swap ? a_eff : b_eff;
    diff  = lg.exp - sm.exp;
    ext_l = W'({lg.exp != '0, lg.frac}) << G;
    ext_s = W'({sm.exp != '0, sm.frac}) << G;
    shifted = ext_s >> diff;
`ifdef FP_ADD_RNE_EN
    shifted[0] = shifted[0] | (|(ext_s & ~({W{1'b1}} << diff)));
`endif
    if (lg.sign == sm.sign) sum = {1'b0, ext_l} + {1'b0, shifted};
    else                    sum = {1'b0, ext_l} - {1'b0, shifted};
  end

  fp32_lzc #(.WIDTH(W)) u_lzc (
    .value (sum[W-1:0]),
    .count (lzc)
  );

  logic signed [9:0] e;
  logic [W-1:0]      norm;
  logic [22:0]       mant;
  fp32_t             res_c;
  logic              exc_c;
`ifdef FP_ADD_RNE_EN
  logic [24:0]       rnd;
`endif

  always_comb begin
    e    = signed'({2'b00, lg.exp});
    norm = sum[W-1:0];
    if (sum[W]) begin
`ifdef FP_ADD_RNE_EN
      norm = {sum[W:2], sum[1] | sum[0]};
`else
      norm = sum[W:1];
`endif
      e = e + 10'sd1;
    end else begin
      norm = sum[W-1:0] << lzc;
      e    = e - signed'({5'b00000, lzc});
    end
`ifdef FP_ADD_RNE_EN
    rnd = {2'b01, norm[W-2:G]} + 25'(norm[2] & (norm[1] | norm[0] | norm[3]));
    if (rnd[24]) begin
      mant = rnd[23:1];
      e    = e + 10'sd1;
    end else begin
      mant = rnd[22:0];
    end
`else
    mant = norm[W-2:G];
`endif
    res_c = '0;
    exc_c = 1'b0;
    // A nonzero sum always normalizes to a set MSB, so a clear MSB means cancellation.
    if (a.exp == EXP_MAX || b.exp == EXP_MAX) begin
      res_c = fp32_t'(FP32_POS_INF);
      exc_c = 1'b1;
    end else if (!norm[W-1]) begin
      res_c = '0;
    end else if (e >= 10'sd255) begin
      res_c = '{sign: lg.sign, exp: EXP_MAX, frac: '0};
      exc_c = 1'b1;
    end else if (e < 10'sd1) begin
      res_c = '0;
    end else begin
      res_c = '{sign: lg.sign, exp: e[7:0], frac: mant};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result    <= '0;
      bus.Exception <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.result    <= res_c;
        bus.Exception <= exc_c;
      end
    end
  end

endmodule

// File: tb/tb_fp32_adder.sv
// Self-checking bench for fp32_adder (truncation build): directed vectors plus random pairs.
module tb_fp32_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;
  logic [32:0] last_exp = '0;

  fp32_adder_if bus();

  fp32_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        x;
  } vec_t;

  vec_t vecs [11];

  // Reference: value-level add following the format rules ({exc, result}).
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    int     ea = int'(a[30:23]);
    int     eb = int'(b[30:23]);
    longint ma, mb, ml, ms, sh, sum;
    longint ka, kb;
    int     el, es, e, diff;
    logic   sl, ss;
    if (ea == 255 || eb == 255) return {1'b1, 32'h7F80_0000};
    ma = (ea == 0) ? 0 : (longint'(a[22:0]) + (longint'(1) << 23));
    mb = (eb == 0) ? 0 : (longint'(b[22:0]) + (longint'(1) << 23));
    if (ma == 0 && mb == 0) return 33'h0;
    ka = (ea == 0) ? 0 : longint'(a[30:0]);
    kb = (eb == 0) ? 0 : longint'(b[30:0]);
    if (ka >= kb) begin
      ml = ma; el = ea; sl = a[31]; ms = mb; es = eb; ss = b[31];
    end else begin
      ml = mb; el = eb; sl = b[31]; ms = ma; es = ea; ss = a[31];
    end
    diff = el - es;
    sh   = (diff >= 24) ? 0 : (ms >> diff);
    sum  = (sl == ss) ? ml + sh : ml - sh;
    if (sum == 0) return 33'h0;
    e = el;
    while (sum >= (longint'(1) << 24)) begin sum = sum >> 1; e++; end
    while (sum <  (longint'(1) << 23)) begin sum = sum << 1; e--; end
    if (e >= 255) return {1'b1, sl, 8'hFF, 23'h0};
    if (e < 1)    return 33'h0;
    return {1'b0, sl, 8'(e), 23'(sum)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid  = v;
    bus.a_operand = a;
    bus.b_operand = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [32:0] exp, input logic ov);
    check({tag, "_res"}, bus.result, exp[31:0]);
    check({tag, "_exc"}, 32'(bus.Exception), 32'(exp[32]));
    check({tag, "_ov"},  32'(bus.out_valid), 32'(ov));
  endtask

  function automatic logic [31:0] rand_pair_b(input logic [31:0] a, input int mode);
    logic [31:0] b;
    int          eb;
    b = $urandom;
    case (mode)
      1: begin
        eb = int'(a[30:23]) + $urandom_range(0, 60) - 30;
        if (eb < 1)   eb = 1;
        if (eb > 254) eb = 254;
        b[30:23] = 8'(eb);
      end
      2: b = {~a[31], a[30:23], a[22:0] ^ 23'($urandom_range(0, 255))};
      3: b[30:23] = 8'($urandom_range(250, 254));
      default: ;
    endcase
    return b;
  endfunction

  initial begin
    logic [31:0] a, b;
    logic [32:0] r;
    int          mode;

    vecs = '{
      '{32'h40A00000, 32'h40000000, 32'h40E00000, 1'b0},
      '{32'h40A00000, 32'h00000000, 32'h40A00000, 1'b0},
      '{32'h7F800000, 32'hC0000000, 32'h7F800000, 1'b1},
      '{32'h7FC00000, 32'h40A00000, 32'h7F800000, 1'b1},
      '{32'h41000000, 32'h00000001, 32'h41000000, 1'b0},
      '{32'hC0000000, 32'hC0200000, 32'hC0900000, 1'b0},
      '{32'h4B70353C, 32'h44B22000, 32'h4B703ACD, 1'b0},
      '{32'h3B27C5AC, 32'h3751B717, 32'h3B289763, 1'b0},
      '{32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1},
      '{32'h00000000, 32'h80000000, 32'h00000000, 1'b0}
    };

    bus.in_valid  = 1'b0;
    bus.a_operand = '0;
    bus.b_operand = '0;

    // Reset state
    #12;
    expect_out("reset", 33'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].a, vecs[i].b);
      expect_out($sformatf("vec%0d", i), {vecs[i].x, vecs[i].r}, 1'b1);
      last_exp = {vecs[i].x, vecs[i].r};
    end

    // in_valid low: outputs hold, out_valid drops
    step(1'b0, 32'h40400000, 32'h40400000);
    expect_out("hold", last_exp, 1'b0);

    // Latency: new operands do not reach the output before the sampling edge
    step(1'b1, 32'h40A00000, 32'h40000000);
    last_exp = {1'b0, 32'h40E00000};
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a_operand = 32'h3F800000;
    bus.b_operand = 32'h3F800000;
    #2;
    check("lat_pre_edge", bus.result, 32'h40E00000);
    @(posedge clk);
    #1;
    expect_out("lat_post_edge", {1'b0, 32'h40000000}, 1'b1);
    step(1'b0, 32'h0, 32'h0);
    check("lat_ov_drop", 32'(bus.out_valid), 32'h0);

    // Asynchronous reset mid-stream
    step(1'b1, 32'h40A00000, 32'h40000000);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 33'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = 33'h0;

    // Randomized pairs against the reference model
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 3);
      a    = $urandom;
      if (mode != 0) a[30:23] = 8'($urandom_range(1, 254));
      if (mode == 3) a[30:23] = 8'($urandom_range(250, 254));
      b = rand_pair_b(a, mode);
      if ($urandom_range(0, 7) == 0) begin
        step(1'b0, a, b);
        expect_out($sformatf("rnd_hold%0d", i), last_exp, 1'b0);
      end else begin
        step(1'b1, a, b);
        r = ref_add(a, b);
        expect_out($sformatf("rnd%0d_%08h_%08h", i, a, b), r, 1'b1);
        last_exp = r;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
